// File: rtl/fifo_pkg.sv
// Sizing helpers and pointer-pair occupancy decode shared by the synchronous FIFO family.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
   } occ_t;

   // Ceiling log2, never below 1 so that a 1- or 2-entry array still gets an address bit.
   function automatic int clog2_safe(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int ptr_w(input int depth);
      return clog2_safe(depth) + 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2_safe(depth + 1);
   endfunction

   // Pointers arrive zero-extended; bit aw is the wrap bit, bits below it address the array.
   function automatic occ_t decode_occ(input logic [31:0] wp, input logic [31:0] rp, input int aw);
      logic [31:0] mask;
      occ_t        o;
      mask    = (32'd1 << aw) - 32'd1;
      o.empty = (wp == rp);
      o.full  = (((wp ^ rp) & mask) == 32'd0) && (wp[aw] != rp[aw]);
      return o;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing signal bundle of sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256
);
   localparam int CW = cnt_w(DEPTH);

   logic             wr_req;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             err_clr;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_req, wr_data, rd_req, err_clr,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_req, wr_data, rd_req, err_clr,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/sync_mem_param.sv
// DEPTH x WIDTH simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
// Array is not reset; only the read register is, so a reset leaves rdata at zero.
module sync_mem_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-address read and write (full with read+write) returns the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO; write visible to a read on the next edge, read data 1 cycle after acceptance.
// No backpressure beyond full/empty: a write at full needs a concurrent accepted read, rejects set sticky errors.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 256,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_param_if.slave bus
);

   localparam int AW = clog2_safe(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          rd_valid_q;
   logic          overflow_q;
   logic          underflow_q;
   logic          rd_acc;
   logic          wr_acc;
   occ_t          occ;

   // Flags depend only on registered pointers, never on this cycle's requests.
   assign occ    = decode_occ(32'(wr_ptr), 32'(rd_ptr), AW);
   assign rd_acc = bus.rd_req & ~occ.empty;
   assign wr_acc = bus.wr_req & (~occ.full | rd_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_valid_q  <= rd_acc;
         overflow_q  <= (bus.wr_req & ~wr_acc) | (overflow_q & ~bus.err_clr);
         underflow_q <= (bus.rd_req & occ.empty) | (underflow_q & ~bus.err_clr);
      end
   end

   sync_mem_param #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.wr_data),
      .re    (rd_acc),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (bus.rd_data)
   );

   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = occ.full;
   assign bus.empty        = occ.empty;
   assign bus.count        = count_q;
   assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
   assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule
